// File: rtl/wb_rx_buf_pkg.sv
// Shared types for the PCIe receive TLP buffer.
// Write FSM states and storage word layout.
package wb_rx_buf_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_PKT  = 2'd1,
    W_DROP = 2'd2
  } wst_t;

  localparam int BAR_W    = 7;
  localparam int WORD_W   = 26;
  localparam int OFF_DATA = 0;
  localparam int OFF_SOP  = 16;
  localparam int OFF_EOP  = 17;
  localparam int OFF_WRN  = 18;
  localparam int OFF_BAR  = 19;

endpackage

// File: rtl/wb_rx_dpram.sv
// Simple dual-port storage for the receive buffer.
// Registered read port returns write data on a same-address collision.
module wb_rx_dpram #(
  parameter int AW = 9,
  parameter int WW = 26
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [WW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [WW-1:0] o_rdata
);

  logic [WW-1:0] r_mem [2**AW];
  logic [WW-1:0] r_q;

  // Write port plus write-first registered read port
  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    if (i_we && (i_waddr == i_raddr))
      r_q <= i_wdata;
    else
      r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/wb_rx_buf.sv
// Receive TLP buffer: stores whole TLPs, drops overflowing or
// truncated ones, and exposes only committed packets to the reader.
module wb_rx_buf
  import wb_rx_buf_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          wb_clk,
  input  logic          rstn,
  input  logic          rx_valid,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_sop,
  input  logic          rx_eop,
  input  logic          rx_wrn,
  input  logic [6:0]    rx_bar,
  input  logic          din_ren,
  output logic [DW-1:0] din,
  output logic          din_sop,
  output logic          din_eop,
  output logic          din_wrn,
  output logic [6:0]    din_bar,
  output logic          tlp_avail,
  output logic          rx_drop,
  output logic [AW:0]   pkt_cnt
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  wst_t            r_state;
  wst_t            w_nstate;
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_wr_commit;
  logic [AW:0]     r_rd_ptr;
  logic [AW:0]     r_pkt_cnt;
  logic            r_drop;
  logic [AW:0]     w_wr_ptr_n;
  logic [AW:0]     w_commit_n;
  logic [AW:0]     w_rd_ptr_n;
  logic [AW-1:0]   w_waddr;
  logic [AW-1:0]   w_raddr;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_q;
  logic            w_we;
  logic            w_sop;
  logic            w_commit;
  logic            w_drop;
  logic            w_full_p;
  logic            w_full_c;
  logic            w_fire;
  logic            w_dec;

  assign w_wdata  = {rx_bar, rx_wrn, rx_eop, rx_sop, rx_data};
  assign w_full_p = (r_wr_ptr - r_rd_ptr) == DEPTH;
  assign w_full_c = (r_wr_commit - r_rd_ptr) == DEPTH;

  // Write FSM next state, write strobe and pointer updates
  always_comb begin
    w_nstate   = r_state;
    w_wr_ptr_n = r_wr_ptr;
    w_commit_n = r_wr_commit;
    w_waddr    = r_wr_ptr[AW-1:0];
    w_we       = 1'b0;
    w_sop      = 1'b0;
    w_commit   = 1'b0;
    w_drop     = 1'b0;
    unique case (r_state)
      W_IDLE, W_DROP: begin
        if (rx_valid && rx_sop)
          w_sop = 1'b1;
        else if (r_state == W_DROP && rx_valid && rx_eop)
          w_nstate = W_IDLE;
      end
      W_PKT: begin
        if (rx_valid) begin
          unique case (1'b1)
            rx_sop: begin
              w_drop = 1'b1;
              w_sop  = 1'b1;
            end
            w_full_p: begin
              w_drop     = 1'b1;
              w_wr_ptr_n = r_wr_commit;
              w_nstate   = rx_eop ? W_IDLE : W_DROP;
            end
            default: begin
              w_we       = 1'b1;
              w_wr_ptr_n = r_wr_ptr + 1'b1;
              if (rx_eop) begin
                w_commit   = 1'b1;
                w_commit_n = r_wr_ptr + 1'b1;
                w_nstate   = W_IDLE;
              end
            end
          endcase
        end
      end
      default: w_nstate = W_IDLE;
    endcase
    // A start word always restarts from the last committed boundary
    if (w_sop) begin
      if (w_full_c) begin
        w_drop     = 1'b1;
        w_wr_ptr_n = r_wr_commit;
        w_nstate   = rx_eop ? W_IDLE : W_DROP;
      end else begin
        w_we       = 1'b1;
        w_waddr    = r_wr_commit[AW-1:0];
        w_wr_ptr_n = r_wr_commit + 1'b1;
        if (rx_eop) begin
          w_commit   = 1'b1;
          w_commit_n = r_wr_commit + 1'b1;
          w_nstate   = W_IDLE;
        end else begin
          w_nstate   = W_PKT;
        end
      end
    end
  end

  // Memory always presents the word at the read pointer
  assign w_fire     = din_ren && (r_rd_ptr != r_wr_commit);
  assign w_rd_ptr_n = w_fire ? r_rd_ptr + 1'b1 : r_rd_ptr;
  assign w_raddr    = w_rd_ptr_n[AW-1:0];
  assign w_dec      = w_fire && w_q[OFF_EOP];

  wb_rx_dpram #(
    .AW (AW),
    .WW (WORD_W)
  ) u_mem (
    .i_clk   (wb_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_q)
  );

  // Write FSM state, pointers, packet count and drop pulse
  always_ff @(posedge wb_clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= W_IDLE;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_rd_ptr    <= '0;
      r_pkt_cnt   <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_nstate;
      r_wr_ptr    <= w_wr_ptr_n;
      r_wr_commit <= w_commit_n;
      r_rd_ptr    <= w_rd_ptr_n;
      r_drop      <= w_drop;
      if (w_commit && !w_dec)
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      else if (!w_commit && w_dec)
        r_pkt_cnt <= r_pkt_cnt - 1'b1;
    end
  end

  // Output word register, loaded only on an accepted read
  always_ff @(posedge wb_clk or negedge rstn) begin
    if (!rstn) begin
      din     <= '0;
      din_sop <= 1'b0;
      din_eop <= 1'b0;
      din_wrn <= 1'b0;
      din_bar <= '0;
    end else if (w_fire) begin
      din     <= w_q[OFF_DATA +: DW];
      din_sop <= w_q[OFF_SOP];
      din_eop <= w_q[OFF_EOP];
      din_wrn <= w_q[OFF_WRN];
      din_bar <= w_q[OFF_BAR +: BAR_W];
    end
  end

  assign pkt_cnt   = r_pkt_cnt;
  assign tlp_avail = (r_pkt_cnt != '0);
  assign rx_drop   = r_drop;

endmodule

// File: tb/tb_wb_rx_buf.sv
// Directed bench for wb_rx_buf with a 16-word buffer.
// Inputs driven after falling edge, outputs checked at falling edge.
module tb_wb_rx_buf;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          wb_clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_sop = 1'b0;
  logic          rx_eop = 1'b0;
  logic          rx_wrn = 1'b0;
  logic [6:0]    rx_bar = '0;
  logic          din_ren = 1'b0;
  logic [DW-1:0] din;
  logic          din_sop;
  logic          din_eop;
  logic          din_wrn;
  logic [6:0]    din_bar;
  logic          tlp_avail;
  logic          rx_drop;
  logic [AW:0]   pkt_cnt;

  int n_chk = 0;
  int n_err = 0;
  int n_drop = 0;
  int d0;

  wb_rx_buf #(.AW(AW), .DW(DW)) dut (
    .wb_clk    (wb_clk),
    .rstn      (rstn),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_sop    (rx_sop),
    .rx_eop    (rx_eop),
    .rx_wrn    (rx_wrn),
    .rx_bar    (rx_bar),
    .din_ren   (din_ren),
    .din       (din),
    .din_sop   (din_sop),
    .din_eop   (din_eop),
    .din_wrn   (din_wrn),
    .din_bar   (din_bar),
    .tlp_avail (tlp_avail),
    .rx_drop   (rx_drop),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 wb_clk = ~wb_clk;

  always @(negedge wb_clk)
    if (rx_drop) n_drop++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] w26(input logic [6:0] b,
    input logic w, input logic e, input logic s,
    input logic [15:0] d);
    return {b, w, e, s, d};
  endfunction

  function automatic logic [25:0] dout();
    return {din_bar, din_wrn, din_eop, din_sop, din};
  endfunction

  task automatic put(input logic [15:0] d, input logic s,
    input logic e, input logic w, input logic [6:0] b);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_sop   = s;
    rx_eop   = e;
    rx_wrn   = w;
    rx_bar   = b;
    @(negedge wb_clk);
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    rx_eop   = 1'b0;
  endtask

  task automatic get(input string tag, input logic [25:0] exp);
    din_ren = 1'b1;
    @(negedge wb_clk);
    din_ren = 1'b0;
    chk(tag, 32'(dout()), 32'(exp));
  endtask

  logic [25:0] q_exp[$];
  logic [25:0] wv;
  int avail;
  bit fire;

  initial begin
    // reset state
    repeat (3) @(negedge wb_clk);
    chk("rst_dout", 32'(dout()), 0);
    chk("rst_cnt", 32'(pkt_cnt), 0);
    chk("rst_av", 32'(tlp_avail), 0);
    rstn = 1'b1;
    @(negedge wb_clk);
    chk("idle_dout", 32'(dout()), 0);
    chk("idle_drop", 32'(rx_drop), 0);

    // 6-word read TLP
    for (int i = 0; i < 6; i++) begin
      put(16'hA000 + 16'(i), i == 0, i == 5, 1'b0, 7'h01);
      if (i == 4) chk("a_av_pre", 32'(tlp_avail), 0);
    end
    chk("a_av", 32'(tlp_avail), 1);
    chk("a_cnt", 32'(pkt_cnt), 1);
    for (int i = 0; i < 6; i++) begin
      get($sformatf("a_rd%0d", i),
          w26(7'h01, 1'b0, i == 5, i == 0, 16'hA000 + 16'(i)));
      if (i == 4) chk("a_cnt_mid", 32'(pkt_cnt), 1);
    end
    chk("a_cnt_end", 32'(pkt_cnt), 0);
    chk("a_av_end", 32'(tlp_avail), 0);
    get("a_hold", w26(7'h01, 1'b0, 1'b1, 1'b0, 16'hA005));

    // overflow: 20 words into 16 slots
    d0 = n_drop;
    for (int i = 0; i < 20; i++) begin
      put(16'hB000 + 16'(i), i == 0, i == 19, 1'b1, 7'h02);
      chk($sformatf("ov_drop%0d", i), 32'(rx_drop), 32'(i == 16));
    end
    chk("ov_ndrop", 32'(n_drop - d0), 1);
    chk("ov_cnt", 32'(pkt_cnt), 0);
    for (int i = 0; i < 4; i++)
      put(16'hC000 + 16'(i), i == 0, i == 3, 1'b1, 7'h03);
    chk("ov_cnt2", 32'(pkt_cnt), 1);
    for (int i = 0; i < 4; i++)
      get($sformatf("ov_rd%0d", i),
          w26(7'h03, 1'b1, i == 3, i == 0, 16'hC000 + 16'(i)));
    chk("ov_cnt3", 32'(pkt_cnt), 0);

    // truncated TLP followed by a good one
    d0 = n_drop;
    for (int i = 0; i < 3; i++)
      put(16'hD000 + 16'(i), i == 0, 1'b0, 1'b0, 7'h04);
    for (int i = 0; i < 4; i++)
      put(16'hE000 + 16'(i), i == 0, i == 3, 1'b0, 7'h05);
    chk("tr_ndrop", 32'(n_drop - d0), 1);
    chk("tr_cnt", 32'(pkt_cnt), 1);
    for (int i = 0; i < 4; i++)
      get($sformatf("tr_rd%0d", i),
          w26(7'h05, 1'b0, i == 3, i == 0, 16'hE000 + 16'(i)));
    chk("tr_av", 32'(tlp_avail), 0);

    // commit of B on same edge as eop read of A
    for (int i = 0; i < 3; i++)
      put(16'hF000 + 16'(i), i == 0, i == 2, 1'b1, 7'h08);
    put(16'h1100, 1'b1, 1'b0, 1'b0, 7'h10);
    put(16'h1101, 1'b0, 1'b0, 1'b0, 7'h10);
    get("sm_a0", w26(7'h08, 1'b1, 1'b0, 1'b1, 16'hF000));
    get("sm_a1", w26(7'h08, 1'b1, 1'b0, 1'b0, 16'hF001));
    rx_valid = 1'b1;
    rx_data  = 16'h1102;
    rx_eop   = 1'b1;
    din_ren  = 1'b1;
    @(negedge wb_clk);
    rx_valid = 1'b0;
    rx_eop   = 1'b0;
    din_ren  = 1'b0;
    chk("sm_a2", 32'(dout()), 32'(w26(7'h08, 1'b1, 1'b1, 1'b0, 16'hF002)));
    chk("sm_cnt", 32'(pkt_cnt), 1);
    chk("sm_av", 32'(tlp_avail), 1);
    for (int i = 0; i < 3; i++)
      get($sformatf("sm_b%0d", i),
          w26(7'h10, 1'b0, i == 2, i == 0, 16'h1100 + 16'(i)));
    chk("sm_cnt2", 32'(pkt_cnt), 0);

    // streaming 100 x 5 words with continuous reads
    d0 = n_drop;
    avail = 0;
    for (int p = 0; p < 100; p++) begin
      for (int w = 0; w < 5; w++) begin
        wv = w26(7'(p), p[0], w == 4, w == 0, 16'(p * 5 + w));
        q_exp.push_back(wv);
        rx_valid = 1'b1;
        {rx_bar, rx_wrn, rx_eop, rx_sop, rx_data} = wv;
        din_ren = 1'b1;
        fire = avail > 0;
        @(negedge wb_clk);
        if (fire) begin
          chk($sformatf("st_%0d_%0d", p, w), 32'(dout()),
              32'(q_exp.pop_front()));
          avail--;
        end
        if (w == 4) avail += 5;
      end
    end
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    rx_eop   = 1'b0;
    for (int k = 0; k < 50 && avail > 0; k++) begin
      @(negedge wb_clk);
      chk($sformatf("st_tail%0d", k), 32'(dout()),
          32'(q_exp.pop_front()));
      avail--;
    end
    din_ren = 1'b0;
    chk("st_left", 32'(q_exp.size()), 0);
    chk("st_ndrop", 32'(n_drop - d0), 0);
    chk("st_cnt", 32'(pkt_cnt), 0);

    // asynchronous reset mid-packet
    put(16'h3000, 1'b1, 1'b0, 1'b0, 7'h20);
    put(16'h3001, 1'b0, 1'b1, 1'b0, 7'h20);
    get("rs_c0", w26(7'h20, 1'b0, 1'b0, 1'b1, 16'h3000));
    chk("rs_cnt_pre", 32'(pkt_cnt), 1);
    put(16'h4000, 1'b1, 1'b0, 1'b1, 7'h40);
    put(16'h4001, 1'b0, 1'b0, 1'b1, 7'h40);
    rx_valid = 1'b1;
    rx_data  = 16'h4002;
    #2;
    rstn = 1'b0;
    #1;
    chk("rs_dout", 32'(dout()), 0);
    chk("rs_cnt", 32'(pkt_cnt), 0);
    chk("rs_av", 32'(tlp_avail), 0);
    chk("rs_drop", 32'(rx_drop), 0);
    rx_valid = 1'b0;
    @(negedge wb_clk);
    rstn = 1'b1;
    @(negedge wb_clk);
    chk("rs_av_post", 32'(tlp_avail), 0);
    for (int i = 0; i < 4; i++)
      put(16'h5000 + 16'(i), i == 0, i == 3, 1'b0, 7'h7F);
    chk("rs_cnt2", 32'(pkt_cnt), 1);
    for (int i = 0; i < 4; i++)
      get($sformatf("rs_rd%0d", i),
          w26(7'h7F, 1'b0, i == 3, i == 0, 16'h5000 + 16'(i)));
    chk("rs_cnt3", 32'(pkt_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
